pe_array_sequencer: RTL and testbench

PE_ARRAY_SEQUENCER -- requirements
Module: pe_array_sequencer

---
 rtl/pe_array_pkg.sv | 18 +
 rtl/pe_array_sequencer_feed_window.sv | 14 +
 rtl/pe_array_sequencer.sv | 111 +++++++++++
 tb/tb_pe_array_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared state encoding, default array size and step-counter width for the PE array sequencer
package pe_array_pkg;
  localparam int N_DEFAULT = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PRELOAD,
    S_STREAM,
    S_DRAIN,
    S_READOUT,
    S_DONE
  } state_t;
  function automatic int STEP_W(input int kw, input int n);
    int need;
    need = $clog2((1 << kw) + 2 * n - 1);
    return (need > kw + 2) ? need : kw + 2;
  endfunction
endpackage

// File: rtl/pe_array_sequencer_feed_window.sv
// feed_window: skewed operand enable, lane r active while r <= t < r + k_len
module feed_window #(
  parameter int N  = 4,
  parameter int KW = 8,
  parameter int TW = 10
) (
  input  logic [TW-1:0] t,
  input  logic [KW-1:0] k_len,
  output logic [N-1:0]  en
);
  always_comb begin
    for (int r = 0; r < N; r++) en[r] = (t >= TW'(r)) && ((t - TW'(r)) < TW'(k_len));
  end
endmodule

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: registered Moore control sequencer for an N x N WS/OS systolic PE array
module pe_array_sequencer
  import pe_array_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int KW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode_os,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 pe_reset,
  output logic                 output_stationary,
  output logic                 preload_valid,
  output logic [$clog2(N)-1:0] preload_row,
  output logic [N-1:0]         row_feed_en,
  output logic [N-1:0]         col_feed_en,
  output logic [KW+1:0]        step,
  output logic                 result_valid
);
  localparam int PW = $clog2(N);
  localparam int SW = STEP_W(KW, N);
  state_t         state, nxt_state;
  logic [SW-1:0]  cnt, nxt_cnt, stream_last;
  logic [KW-1:0]  k_q, nxt_k;
  logic           mode_q, nxt_mode;
  logic [N-1:0]   row_en, col_en;
  logic           pv_n, strm_n;
  assign stream_last = SW'(k_q) + SW'(N - 2) + (mode_q ? SW'(N - 1) : SW'(0));
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_k     = k_q;
    nxt_mode  = mode_q;
    if (state == S_IDLE) begin
      if (start && !abort) begin
        nxt_k     = k_len;
        nxt_mode  = mode_os;
        nxt_cnt   = '0;
        nxt_state = (k_len == '0) ? S_DONE : mode_os ? S_CLEAR : S_PRELOAD;
      end
    end else if (abort) begin
      nxt_state = S_IDLE;
      nxt_cnt   = '0;
    end else begin
      case (state)
        S_CLEAR: begin
          nxt_state = S_STREAM;
          nxt_cnt   = '0;
        end
        S_PRELOAD: begin
          nxt_state = (cnt == SW'(N - 1)) ? S_STREAM : S_PRELOAD;
          nxt_cnt   = (cnt == SW'(N - 1)) ? '0 : cnt + 1'b1;
        end
        S_STREAM: begin
          nxt_state = (cnt != stream_last) ? S_STREAM : mode_q ? S_READOUT : S_DRAIN;
          nxt_cnt   = (cnt == stream_last) ? '0 : cnt + 1'b1;
        end
        S_DRAIN, S_READOUT: begin
          nxt_state = (cnt == SW'(N - 1)) ? S_DONE : state;
          nxt_cnt   = (cnt == SW'(N - 1)) ? '0 : cnt + 1'b1;
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end
  assign pv_n   = (nxt_state == S_PRELOAD) || (nxt_state == S_READOUT);
  assign strm_n = (nxt_state == S_STREAM);
  feed_window #(.N(N), .KW(KW), .TW(SW)) u_row_window (.t(nxt_cnt), .k_len(nxt_k), .en(row_en));
  feed_window #(.N(N), .KW(KW), .TW(SW)) u_col_window (.t(nxt_cnt), .k_len(nxt_k), .en(col_en));
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      k_q               <= '0;
      mode_q            <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      pe_reset          <= 1'b0;
      output_stationary <= 1'b0;
      preload_valid     <= 1'b0;
      preload_row       <= '0;
      row_feed_en       <= '0;
      col_feed_en       <= '0;
      step              <= '0;
      result_valid      <= 1'b0;
    end else begin
      state             <= nxt_state;
      cnt               <= nxt_cnt;
      k_q               <= nxt_k;
      mode_q            <= nxt_mode;
      busy              <= nxt_state != S_IDLE;
      done              <= nxt_state == S_DONE;
      pe_reset          <= nxt_state == S_CLEAR;
      output_stationary <= (nxt_state != S_IDLE) && nxt_mode;
      preload_valid     <= pv_n;
      preload_row       <= pv_n ? nxt_cnt[PW-1:0] : '0;
      row_feed_en       <= strm_n ? row_en : '0;
      col_feed_en       <= (strm_n && nxt_mode) ? col_en : '0;
      step              <= strm_n ? nxt_cnt[KW+1:0] : '0;
      result_valid      <= (nxt_state == S_DRAIN) || (nxt_state == S_READOUT);
    end
  end
endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb_pe_array_sequencer: directed cycle-accurate checks of the PE array sequencer at N=4, KW=8
module tb_pe_array_sequencer;
  localparam int N  = 4;
  localparam int KW = 8;
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           mode_os = 1'b0;
  logic [KW-1:0]  k_len = '0;
  logic           busy, done, pe_reset, output_stationary, preload_valid, result_valid;
  logic [1:0]     preload_row;
  logic [N-1:0]   row_feed_en, col_feed_en;
  logic [KW+1:0]  step;
  int             checks = 0;
  int             failures = 0;
  logic [3:0]     feed_tbl [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
  always #5 clk = ~clk;
  pe_array_sequencer #(.N(N), .KW(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode_os(mode_os), .k_len(k_len),
    .busy(busy), .done(done), .pe_reset(pe_reset), .output_stationary(output_stationary),
    .preload_valid(preload_valid), .preload_row(preload_row), .row_feed_en(row_feed_en),
    .col_feed_en(col_feed_en), .step(step), .result_valid(result_valid)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_outs(input string tag, input logic [5:0] flags, input int prow, input int rfe, input int cfe, input int st);
    check({tag, " flags"}, 32'({busy, done, pe_reset, output_stationary, preload_valid, result_valid}), 32'(flags));
    check({tag, " prow"}, 32'(preload_row), prow);
    check({tag, " row_en"}, 32'(row_feed_en), rfe);
    check({tag, " col_en"}, 32'(col_feed_en), cfe);
    check({tag, " step"}, 32'(step), st);
  endtask
  task automatic run_ws(input string tag, input bit disturb);
    start = 1'b1; mode_os = 1'b0; k_len = 8'd3;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      bit s;
      int t;
      s = (c >= 5) && (c <= 10);
      t = s ? c - 5 : 0;
      expect_outs($sformatf("%s c%0d", tag, c),
                  {c <= 15, c == 15, 1'b0, 1'b0, c <= 4, (c >= 11) && (c <= 14)},
                  (c <= 4) ? c - 1 : 0, s ? int'(feed_tbl[t]) : 0, 0, s ? t : 0);
      if (disturb) begin
        start   = (c >= 5) && (c <= 9);
        mode_os = start;
        k_len   = start ? 8'd9 : 8'd3;
      end
      tick;
    end
  endtask
  initial begin
    start = 1'b1; abort = 1'b1; mode_os = 1'b1; k_len = 8'd3;
    tick;
    tick;
    expect_outs("reset", 6'b0, 0, 0, 0, 0);
    start = 1'b0; abort = 1'b0; mode_os = 1'b0;
    reset = 1'b0;
    tick;
    expect_outs("idle", 6'b0, 0, 0, 0, 0);
    run_ws("ws", 1'b0);
    start = 1'b1; mode_os = 1'b1; k_len = 8'd3;
    tick;
    start = 1'b0; mode_os = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      bit s;
      int t;
      int fe;
      s  = (c >= 2) && (c <= 10);
      t  = s ? c - 2 : 0;
      fe = (s && t <= 5) ? int'(feed_tbl[t]) : 0;
      expect_outs($sformatf("os c%0d", c),
                  {c <= 15, c == 15, c == 1, c <= 15, (c >= 11) && (c <= 14), (c >= 11) && (c <= 14)},
                  (c >= 11 && c <= 14) ? c - 11 : 0, fe, fe, s ? t : 0);
      tick;
    end
    start = 1'b1; k_len = 8'd0;
    tick;
    start = 1'b0;
    expect_outs("k0 c1", 6'b110000, 0, 0, 0, 0);
    tick;
    expect_outs("k0 c2", 6'b0, 0, 0, 0, 0);
    run_ws("ws_dist", 1'b1);
    start = 1'b1; mode_os = 1'b0; k_len = 8'd3;
    tick;
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick;
    expect_outs("pre_abort", 6'b100000, 0, 4'b0111, 0, 2);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    expect_outs("abort c1", 6'b0, 0, 0, 0, 0);
    tick;
    expect_outs("abort c2", 6'b0, 0, 0, 0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    expect_outs("pre_reset", 6'b100010, 1, 0, 0, 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    expect_outs("reset_mid c1", 6'b0, 0, 0, 0, 0);
    tick;
    expect_outs("reset_mid c2", 6'b0, 0, 0, 0, 0);
    start = 1'b1; abort = 1'b1;
    tick;
    expect_outs("abort_idle", 6'b0, 0, 0, 0, 0);
    abort = 1'b0; mode_os = 1'b0; k_len = 8'd255;
    tick;
    for (int c = 1; c <= 269; c++) begin
      if (c == 260) begin
        check("b2b step255", 32'(step), 255);
        check("b2b row255", 32'(row_feed_en), 4'b1110);
      end
      if (c == 262) begin
        check("b2b step257", 32'(step), 257);
        check("b2b row257", 32'(row_feed_en), 4'b1000);
      end
      if (c == 263) begin
        check("b2b drain step", 32'(step), 0);
        check("b2b drain rv", 32'(result_valid), 1);
      end
      if (c == 266) check("b2b no early done", 32'(done), 0);
      if (c == 267) check("b2b done", 32'({busy, done, result_valid}), 3'b110);
      if (c == 268) check("b2b idle", 32'({busy, done}), 2'b00);
      if (c == 269) check("b2b restart", 32'({busy, preload_valid, preload_row}), 4'b1100);
      if (c < 269) tick;
    end
    start = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
    check("final idle", 32'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
